// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-port data memory with lane steering and load extension.
// Latency: grant is combinational with the request; the response appears on the owner one cycle later.
// Backpressure: a requester that is not granted holds its request until gnt; round-robin decides conflicts.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_size,
    input  logic          m0_unsigned,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_size,
    input  logic          m1_unsigned,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // last_grant_q = 1 means port 1 was served most recently, so port 0 wins the next conflict
    logic          last_grant_q, last_grant_d;

    logic          rsp_vld_q,  rsp_vld_d;
    logic          rsp_own_q,  rsp_own_d;
    logic          rsp_we_q,   rsp_we_d;
    logic [1:0]    rsp_size_q, rsp_size_d;
    logic          rsp_uns_q,  rsp_uns_d;
    logic [1:0]    rsp_off_q,  rsp_off_d;
    logic          rsp_err_q,  rsp_err_d;

    logic          any_gnt;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic          sel_uns;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;
    logic [3:0]    lane_be;
    logic [DW-1:0] lane_wd;

    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [DW-1:0] load_data;
    logic [DW-1:0] rsp_data;

    // Round-robin grant: a lone requester always wins, a conflict goes to the port not served last
    always_comb begin
        m0_gnt  = m0_req & (~m1_req | last_grant_q);
        m1_gnt  = m1_req & (~m0_req | ~last_grant_q);
        any_gnt = m0_gnt | m1_gnt;
    end

    // Select the granted port's request fields
    always_comb begin
        sel_we    = m1_gnt ? m1_we       : m0_we;
        sel_size  = m1_gnt ? m1_size     : m0_size;
        sel_uns   = m1_gnt ? m1_unsigned : m0_unsigned;
        sel_addr  = m1_gnt ? m1_addr     : m0_addr;
        sel_wdata = m1_gnt ? m1_wdata    : m0_wdata;
    end

    // Alignment check, lane enables and data replication for the selected request
    always_comb begin
        sel_err = 1'b0;
        lane_be = 4'b0000;
        lane_wd = sel_wdata;
        case (sel_size)
            SZ_BYTE: begin
                lane_be = 4'b0001 << sel_addr[1:0];
                lane_wd = {4{sel_wdata[7:0]}};
            end
            SZ_HALF: begin
                sel_err = sel_addr[0];
                lane_be = 4'b0011 << sel_addr[1:0];
                lane_wd = {2{sel_wdata[15:0]}};
            end
            SZ_WORD: begin
                sel_err = (sel_addr[1:0] != 2'b00);
                lane_be = 4'b1111;
            end
            default: begin
                sel_err = 1'b1;
            end
        endcase
    end

    // Memory drive: quiet when idle; loads and erroring accesses never enable lanes or write
    always_comb begin
        mem_we = any_gnt & sel_we & ~sel_err;
        mem_be = mem_we ? lane_be : 4'b0000;
        mem_a  = any_gnt ? sel_addr : '0;
        mem_wd = any_gnt ? lane_wd : '0;
    end

    // Next-state for the arbitration pointer and the response pipeline stage
    always_comb begin
        last_grant_d = any_gnt ? m1_gnt : last_grant_q;
        rsp_vld_d    = any_gnt;
        rsp_own_d    = m1_gnt;
        rsp_we_d     = sel_we;
        rsp_size_d   = sel_size;
        rsp_uns_d    = sel_uns;
        rsp_off_d    = sel_addr[1:0];
        rsp_err_d    = sel_err;
    end

    // Capture the granted access so its response can be formed next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp_vld_q    <= 1'b0;
            rsp_own_q    <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_size_q   <= 2'b00;
            rsp_uns_q    <= 1'b0;
            rsp_off_q    <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_own_q    <= rsp_own_d;
            rsp_we_q     <= rsp_we_d;
            rsp_size_q   <= rsp_size_d;
            rsp_uns_q    <= rsp_uns_d;
            rsp_off_q    <= rsp_off_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Pick the addressed byte/half out of the memory word and extend it
    always_comb begin
        case (rsp_off_q)
            2'd0:    rd_byte = mem_rd[7:0];
            2'd1:    rd_byte = mem_rd[15:8];
            2'd2:    rd_byte = mem_rd[23:16];
            default: rd_byte = mem_rd[31:24];
        endcase
        rd_half = rsp_off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (rsp_size_q)
            SZ_BYTE: load_data = {{24{~rsp_uns_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = {{16{~rsp_uns_q & rd_half[15]}}, rd_half};
            default: load_data = mem_rd;
        endcase
        rsp_data = (rsp_vld_q & ~rsp_we_q & ~rsp_err_q) ? load_data : '0;
    end

    // Route the response to its owner only; the other port sees zeros
    always_comb begin
        m0_rvalid = rsp_vld_q & ~rsp_own_q;
        m1_rvalid = rsp_vld_q &  rsp_own_q;
        m0_err    = m0_rvalid & rsp_err_q;
        m1_err    = m1_rvalid & rsp_err_q;
        m0_rdata  = m0_rvalid ? rsp_data : '0;
        m1_rdata  = m1_rvalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses against a small word memory model.
// Expected responses are queued per port at grant time and checked by a monitor on rvalid.
// Inputs change 1 ns after the rising edge; outputs are sampled away from the edge.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_unsigned;
    logic [1:0]    m0_size;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_unsigned;
    logic [1:0]    m1_size;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m1_rdata;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Synchronous-read, byte-enabled word memory
    logic [31:0] mem [0:63];
    logic        clr_mem;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem_rd <= 32'h0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (mem_we && mem_be[l]) mem[mem_a[7:2]][l*8 +: 8] <= mem_wd[l*8 +: 8];
            mem_rd <= mem[mem_a[7:2]];
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation for that port
    always @(negedge clk) begin
        if (m0_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL m0 unexpected rvalid: got rdata %h err %b expected no response", m0_rdata, m0_err);
            end else begin
                e0 = q0.pop_front();
                check("m0 rdata", m0_rdata, e0[31:0]);
                check("m0 err", {31'b0, m0_err}, {31'b0, e0[32]});
            end
        end
        if (m1_rvalid === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL m1 unexpected rvalid: got rdata %h err %b expected no response", m1_rdata, m1_err);
            end else begin
                e1 = q1.pop_front();
                check("m1 rdata", m1_rdata, e1[31:0]);
                check("m1 err", {31'b0, m1_err}, {31'b0, e1[32]});
            end
        end
    end

    task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_size = size; m0_unsigned = uns; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_size = size; m1_unsigned = uns; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One uncontended access: check the grant cycle, queue the expected response
    task automatic access(input string tag, input int p, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic exp_we, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, size, uns, addr, wdata);
        #1;
        check({tag, " gnt"},   {31'b0, (p == 0) ? m0_gnt : m1_gnt}, 32'd1);
        check({tag, " other"}, {31'b0, (p == 0) ? m1_gnt : m0_gnt}, 32'd0);
        check({tag, " be"},    {28'b0, mem_be}, {28'b0, exp_be});
        check({tag, " we"},    {31'b0, mem_we}, {31'b0, exp_we});
        check({tag, " addr"},  mem_a, addr);
        if (exp_we) check({tag, " wd"}, mem_wd, exp_wd);
        if (p == 0) q0.push_back({exp_err, exp_rdata});
        else        q1.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_mem = 1'b1;
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        check("rst m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        check("rst m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("rst m0_err",    {31'b0, m0_err},    32'd0);
        check("rst m1_err",    {31'b0, m1_err},    32'd0);
        check("rst m0_rdata",  m0_rdata, 32'h0);
        check("rst m1_rdata",  m1_rdata, 32'h0);
        check("idle mem_we",   {31'b0, mem_we}, 32'd0);
        check("idle mem_be",   {28'b0, mem_be}, 32'd0);
        check("idle mem_a",    mem_a,  32'h0);
        check("idle mem_wd",   mem_wd, 32'h0);
        clr_mem = 1'b0;
        @(negedge clk) reset = 1'b0;

        // Port 0 word, byte and half traffic
        access("sw0",  0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 1, 32'hDEADBEEF, 32'h0,        0);
        access("lw0",  0, 0, 2'b10, 0, 32'h10, 32'h0,        4'b0000, 0, 32'h0,        32'hDEADBEEF, 0);
        access("sb0",  0, 1, 2'b00, 0, 32'h21, 32'h12345680, 4'b0010, 1, 32'h80808080, 32'h0,        0);
        access("lb0",  0, 0, 2'b00, 0, 32'h21, 32'h0,        4'b0000, 0, 32'h0,        32'hFFFFFF80, 0);
        access("lbu0", 0, 0, 2'b00, 1, 32'h21, 32'h0,        4'b0000, 0, 32'h0,        32'h00000080, 0);
        access("sh0",  0, 1, 2'b01, 0, 32'h22, 32'h0000A5C3, 4'b1100, 1, 32'hA5C3A5C3, 32'h0,        0);
        access("lh0",  0, 0, 2'b01, 0, 32'h22, 32'h0,        4'b0000, 0, 32'h0,        32'hFFFFA5C3, 0);
        access("lhu0", 0, 0, 2'b01, 1, 32'h22, 32'h0,        4'b0000, 0, 32'h0,        32'h0000A5C3, 0);
        access("lw20", 0, 0, 2'b10, 0, 32'h20, 32'h0,        4'b0000, 0, 32'h0,        32'hA5C38000, 0);
        access("lb23", 0, 0, 2'b00, 0, 32'h23, 32'h0,        4'b0000, 0, 32'h0,        32'hFFFFFFA5, 0);

        // Port 1 misaligned and reserved-size accesses, then readback
        access("shx1", 1, 1, 2'b01, 0, 32'h03, 32'h0000BEEF, 4'b0000, 0, 32'h0,        32'h0,        1);
        access("lwx1", 1, 0, 2'b10, 0, 32'h06, 32'h0,        4'b0000, 0, 32'h0,        32'h0,        1);
        access("swr1", 1, 1, 2'b11, 0, 32'h08, 32'h55555555, 4'b0000, 0, 32'h0,        32'h0,        1);
        access("rb00", 1, 0, 2'b10, 0, 32'h00, 32'h0,        4'b0000, 0, 32'h0,        32'h0,        0);
        access("rb04", 1, 0, 2'b10, 0, 32'h04, 32'h0,        4'b0000, 0, 32'h0,        32'h0,        0);
        access("rb08", 1, 0, 2'b10, 0, 32'h08, 32'h0,        4'b0000, 0, 32'h0,        32'h0,        0);
        access("lw1",  1, 0, 2'b10, 0, 32'h10, 32'h0,        4'b0000, 0, 32'h0,        32'hDEADBEEF, 0);

        // Reset right after a port 0 load grant drops its response
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        #1;
        check("rst-load gnt", {31'b0, m0_gnt}, 32'd1);
        @(posedge clk);
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #2;
        check("rst-load rvalid", {31'b0, m0_rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check("rst-load rvalid hold", {31'b0, m0_rvalid}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Both ports request continuously: grants alternate starting with port 0
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("arb m0_gnt", {31'b0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("arb m1_gnt", {31'b0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("arb mem_a",  mem_a, (i % 2 == 0) ? 32'h10 : 32'h20);
            if (i % 2 == 0) q0.push_back({1'b0, 32'hDEADBEEF});
            else            q1.push_back({1'b0, 32'hA5C38000});
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #6;

        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA engine.
- Per requester, the block handles request/grant arbitration, byte-lane generation, write-data lane steering and read-data extraction with sign/zero extension.
- It checks alignment and routes each 1-cycle-latency memory response back to its owner.
- It sits between the requesters and the data memory, which has a synchronous read, byte-enabled write, and word addressing via a[31:2].

Parameters:
- AW, 32, address width of requester and memory address buses
- DW, 32, data width; fixed at 32, four byte lanes

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- m0_req  in  1  port 0 request valid
- m0_we  in  1  port 0 store (1) / load (0)
- m0_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- m0_unsigned  in  1  zero-extend load result (1) / sign-extend (0)
- m0_addr  in  AW  byte address
- m0_wdata  in  DW  store data, right-aligned (LSB-justified)
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  response valid, one cycle after gnt
- m0_rdata  out  DW  extended load data; 0 for stores and on error
- m0_err  out  1  misaligned or reserved-size access, qualified by rvalid
- m1_*  —  identical set for port 1
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_a  out  AW  memory address; low 2 bits = granted addr[1:0]
- mem_wd  out  DW  lane-steered write data
- mem_rd  in  DW  memory read word, valid the cycle after the access edge

Behaviour:
- Reset (async): last_grant=1, so port 0 wins the first conflict. All response registers clear; m*_rvalid=0, m*_err=0, m*_rdata=0.
- Grant is combinational in the same cycle as req.
  - Single requester: it is granted.
  - Both requesting: the port not granted last is granted.
  - last_grant updates only on a grant.
  - At most one gnt per cycle; no grant when no req.
- Requests are not queued. An un-granted requester must hold req and all its fields stable until gnt.
- Memory-side drive:
  - Idle cycle: mem_we=0, mem_be=0, mem_a=0, mem_wd=0.
  - Granted cycle: mem_a=addr.
  - Byte lane enables: byte → 1<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
  - mem_wd replicates the data across lanes: byte into all four lanes, half into both halves, word as-is.
  - mem_we = we & aligned.
  - A load drives mem_be=0000 and mem_we=0.
- Alignment: error if size=11, half with addr[0]=1, or word with addr[1:0]≠00.
  - An erroring request is still granted.
  - mem_we=0 and mem_be=0000, so memory is untouched.
- Response registers are captured at the grant edge: valid, owner, we, size, unsigned, addr[1:0], err.
- In the next cycle only the owner sees rvalid=1, for both loads and stores.
- Load rdata is formed combinationally from mem_rd:
  - Byte/half are selected by the captured addr[1:0] and sign- or zero-extended.
  - Word is passed through.
- Store responses carry rdata=0. Error responses carry rdata=0, err=1.
- Back-to-back: a new grant may occur in the same cycle a response is presented, giving full throughput of one access per cycle.
- Reset asserted mid-transaction: the pending response is dropped, and the memory write of a cycle coinciding with reset is not guaranteed.

Test Plan:
- Port 0 only: store word 0xDEADBEEF @0x10, then load word @0x10 → gnt same cycle; mem_be=1111 on the store; load rvalid next cycle, rdata=0xDEADBEEF, err=0.
- Byte/half lanes: store byte 0x80 @0x21 → mem_be=0010, mem_wd=0x80808080. Load byte signed @0x21 → 0xFFFFFF80; unsigned → 0x00000080.
- Both ports request continuously from reset → grants alternate 0,1,0,1. Each rvalid appears only on the owner one cycle after its gnt, with no lost or duplicated responses.
- Misaligned: port 1 half store @0x03, then word load @0x06 → both granted with mem_we=0 and mem_be=0000; rvalid with err=1, rdata=0; memory contents unchanged on readback.
- Reset asserted the cycle after a port 0 load gnt → m0_rvalid stays 0. After release, port 0 wins the first conflict.
